// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Image layout: LEN_BYTES length bytes, then BYTES_PER_WORD bytes per word, MSB first.
package imem_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_BYTE,
    ST_WRITE,
    ST_FINISH,
    ST_ERR
  } boot_state_t;

  localparam int BYTES_PER_WORD      = 4;
  localparam int LEN_BYTES           = 2;
  localparam int DEFAULT_MEM_WORDS   = 151;
  localparam int DEFAULT_TIMEOUT_CYC = 1000000;

  // States in which a load is in progress (CPU held in stall and reset).
  function automatic logic is_loading(input boot_state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_BYTE) ||
           (s == ST_WRITE)  || (s == ST_FINISH);
  endfunction

  // States that accept bytes from the stream.
  function automatic logic is_receiving(input boot_state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_BYTE);
  endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Packs stream bytes MSB-first into one instruction word and flags the
// byte that completes it.
module imem_word_assembler
  import imem_boot_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        i_clear,
  input  logic                        i_shift,
  input  logic [7:0]                  i_byte,
  output logic [8*BYTES_PER_WORD-1:0] o_word,
  output logic                        o_word_complete
);

  localparam int WORD_W = 8 * BYTES_PER_WORD;

  logic [WORD_W-1:0] r_word;
  logic [1:0]        r_byte_cnt;

  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_word     <= '0;
      r_byte_cnt <= '0;
    end else if (i_shift) begin
      r_word     <= {r_word[WORD_W-9:0], i_byte};
      r_byte_cnt <= r_byte_cnt + 2'd1;
    end
  end

  assign o_word          = r_word;
  assign o_word_complete = i_shift && (r_byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_controller.sv
// Boot loader: receives a length-prefixed image from a byte stream, writes it
// into instruction memory, and owns the memory port mux between CPU and loader.
module imem_boot_controller
  import imem_boot_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int MEM_WORDS   = DEFAULT_MEM_WORDS,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              cpu_stall,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int LEN_W   = 8 * LEN_BYTES;
  localparam int TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  boot_state_t r_state;
  boot_state_t w_state_next;

  logic [LEN_W-1:0]            r_len;
  logic [ADDR_W-1:0]           r_word_idx;
  logic [TO_W-1:0]             r_timeout_cnt;
  logic                        r_byte_ready;
  logic                        r_mem_we;
  logic                        r_cpu_stall;
  logic                        r_cpu_reset;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_error;

  logic                        w_xfer;
  logic                        w_timeout;
  logic                        w_last_word;
  logic                        w_word_complete;
  logic [LEN_W-1:0]            w_len_full;
  logic [8*BYTES_PER_WORD-1:0] w_word;

  assign w_xfer      = byte_valid && r_byte_ready;
  assign w_len_full  = {r_len[LEN_W-9:0], byte_data};
  assign w_timeout   = (TIMEOUT_CYC != 0) && !w_xfer && (r_timeout_cnt == TO_W'(TO_LAST));
  assign w_last_word = (32'(r_word_idx) + 32'd1) == 32'(r_len);

  imem_word_assembler u_assembler (
    .clock           (clock),
    .reset           (reset),
    .i_clear         ((r_state == ST_LEN_HI) || (r_state == ST_LEN_LO)),
    .i_shift         ((r_state == ST_BYTE) && w_xfer),
    .i_byte          (byte_data),
    .o_word          (w_word),
    .o_word_complete (w_word_complete)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_ERR: begin
        if (start) w_state_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (w_xfer)         w_state_next = ST_LEN_LO;
        else if (w_timeout) w_state_next = ST_ERR;
      end
      ST_LEN_LO: begin
        if (w_xfer) begin
          if (w_len_full == '0)                       w_state_next = ST_FINISH;
          else if (32'(w_len_full) > 32'(MEM_WORDS))  w_state_next = ST_ERR;
          else                                        w_state_next = ST_BYTE;
        end else if (w_timeout) begin
          w_state_next = ST_ERR;
        end
      end
      ST_BYTE: begin
        if (w_word_complete) w_state_next = ST_WRITE;
        else if (w_timeout)  w_state_next = ST_ERR;
      end
      ST_WRITE:  w_state_next = w_last_word ? ST_FINISH : ST_BYTE;
      ST_FINISH: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_len         <= '0;
      r_word_idx    <= '0;
      r_timeout_cnt <= '0;
      r_byte_ready  <= 1'b0;
      r_mem_we      <= 1'b0;
      r_cpu_stall   <= 1'b0;
      r_cpu_reset   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_byte_ready <= is_receiving(w_state_next);
      r_mem_we     <= (w_state_next == ST_WRITE);
      r_busy       <= is_loading(w_state_next);
      r_cpu_stall  <= is_loading(w_state_next) || (w_state_next == ST_ERR);
      r_cpu_reset  <= is_loading(w_state_next) || (w_state_next == ST_ERR);
      r_done       <= (w_state_next == ST_FINISH);
      r_error      <= (w_state_next == ST_ERR);

      if (((r_state == ST_LEN_HI) || (r_state == ST_LEN_LO)) && w_xfer)
        r_len <= w_len_full;

      if (((r_state == ST_IDLE) || (r_state == ST_ERR)) && start)
        r_word_idx <= '0;
      else if (r_state == ST_WRITE)
        r_word_idx <= r_word_idx + 1'b1;

      // Idle counter restarts on any transfer or state change.
      if (w_xfer || (w_state_next != r_state) || !is_receiving(r_state))
        r_timeout_cnt <= '0;
      else
        r_timeout_cnt <= r_timeout_cnt + 1'b1;
    end
  end

  assign mem_addr   = (r_state == ST_IDLE) ? cpu_addr : r_word_idx;
  assign mem_wdata  = DATA_W'(w_word);
  assign mem_we     = r_mem_we;
  assign byte_ready = r_byte_ready;
  assign cpu_stall  = r_cpu_stall;
  assign cpu_reset  = r_cpu_reset;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_imem_boot_controller.sv
// Randomised bench for imem_boot_controller with a byte-count level reference
// model compared every cycle, plus literal expectations for the directed loads.
module tb_imem_boot_controller;

  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 32;
  localparam int MEM_WORDS = 151;
  localparam int TO        = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic [ADDR_W-1:0] cpu_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              cpu_stall;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              error;

  always #5 clock = ~clock;

  imem_boot_controller #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .MEM_WORDS   (MEM_WORDS),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .cpu_addr   (cpu_addr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .cpu_stall  (cpu_stall),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  // Instruction memory seen by the DUT, plus event counters.
  logic [31:0] tb_mem [MEM_WORDS] = '{default: 32'h0};
  int we_count   = 0;
  int done_count = 0;
  int bad_addr   = 0;

  always @(posedge clock) begin
    if (mem_we) begin
      if (mem_addr < MEM_WORDS) tb_mem[mem_addr] <= mem_wdata;
      else                      bad_addr <= bad_addr + 1;
      we_count <= we_count + 1;
    end
    if (done) done_count <= done_count + 1;
  end

  // Reference model: mode 0 idle, 1 loading, 2 error; progress tracked by bytes accepted.
  int          m_mode = 0;
  int          m_nb   = 0;
  int          m_n    = 0;
  int          m_idle = 0;
  int          m_widx = 0;
  bit          m_wr   = 1'b0;
  bit          m_fin  = 1'b0;
  logic [7:0]  m_hi   = 8'h0;
  logic [31:0] m_word = 32'h0;
  logic [31:0] m_mem [MEM_WORDS] = '{default: 32'h0};

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  function automatic bit m_ready();
    return (m_mode == 1) && !m_wr && !m_fin;
  endfunction

  function automatic logic [ADDR_W-1:0] m_addr();
    return (m_mode == 0) ? cpu_addr : ADDR_W'(m_widx);
  endfunction

  task automatic model_step();
    bit xfer;
    xfer = byte_valid && m_ready();
    if (reset) begin
      m_mode = 0; m_nb = 0; m_n = 0; m_idle = 0; m_widx = 0;
      m_wr = 1'b0; m_fin = 1'b0; m_word = 32'h0;
    end else if (m_mode != 1) begin
      if (start) begin
        m_mode = 1; m_nb = 0; m_idle = 0; m_widx = 0; m_wr = 1'b0; m_fin = 1'b0;
      end
    end else if (m_fin) begin
      m_mode = 0;
      m_fin  = 1'b0;
    end else if (m_wr) begin
      m_mem[m_widx] = m_word;
      m_widx++;
      m_wr   = 1'b0;
      m_idle = 0;
      if (m_widx == m_n) m_fin = 1'b1;
    end else if (xfer) begin
      if (m_nb == 0) begin
        m_hi = byte_data;
      end else if (m_nb == 1) begin
        m_n = {m_hi, byte_data};
        if (m_n == 0)              m_fin  = 1'b1;
        else if (m_n > MEM_WORDS)  m_mode = 2;
      end else begin
        m_word = {m_word[23:0], byte_data};
        if ((m_nb - 2) % 4 == 3) m_wr = 1'b1;
      end
      m_nb++;
      m_idle = 0;
    end else begin
      m_idle++;
      if (m_idle == TO) m_mode = 2;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare against the model at the falling edge, step the model at the rising edge.
  task automatic cyc();
    logic [63:0] act;
    logic [63:0] exp;
    @(negedge clock);
    if (chk_en) begin
      exp = {15'd0, m_ready(), m_wr, m_mode != 0, m_mode != 0, m_mode == 1, m_fin, m_mode == 2,
             m_addr(), m_wr ? m_word : 32'h0};
      act = {15'd0, byte_ready, mem_we, cpu_stall, cpu_reset, busy, done, error,
             mem_addr, mem_we ? mem_wdata : 32'h0};
      check("cycle", act, exp);
    end
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    byte_valid = 1'b0;
    repeat (gap) cyc();
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 40) begin
      cyc();
      n++;
    end
    if (n >= 40) begin
      checks++;
      failures++;
      $display("FAIL handshake byte_ready stayed 0 for %0d cycles, required 1", n);
    end
    cyc();
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
  endtask

  task automatic send_len(input logic [15:0] n, input int gmax);
    send_byte(n[15:8], $urandom_range(0, gmax));
    send_byte(n[7:0],  $urandom_range(0, gmax));
  endtask

  task automatic send_word(input logic [31:0] w, input int gmax);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], $urandom_range(0, gmax));
  endtask

  task automatic wait_done(input int maxc);
    int n;
    n = 0;
    while (!done && n < maxc) begin
      cyc();
      n++;
    end
    check("done_seen", {63'd0, done}, 64'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cpu_addr = ADDR_W'($urandom);
      cyc();
    end
  endtask

  initial begin
    int          we0;
    int          dn0;
    int          k;
    int          nw;
    int          bad;
    logic [31:0] words [16];

    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h0; cpu_addr = 10'h03A;
    cyc();
    chk_en = 1'b1;
    cyc();
    check("reset_outputs",
          {31'd0, byte_ready, mem_we, cpu_stall, cpu_reset, busy, done, error, mem_wdata}, 64'd0);
    check("reset_mem_addr", {54'd0, mem_addr}, 64'h03A);
    reset = 1'b0;
    idle_cycles(3);
    cpu_addr = 10'h03A;

    // Normal two-word load.
    we0 = we_count; dn0 = done_count;
    pulse_start();
    send_len(16'd2, 0);
    send_word(32'h5C000052, 0);
    send_word(32'h2C630007, 0);
    wait_done(10);
    cyc();
    check("normal_stall_falls", {63'd0, cpu_stall}, 64'd0);
    check("normal_mux_cpu", {54'd0, mem_addr}, 64'h03A);
    check("normal_writes", 64'(we_count - we0), 64'd2);
    check("normal_done_pulses", 64'(done_count - dn0), 64'd1);
    check("normal_mem0", {32'd0, tb_mem[0]}, 64'h5C000052);
    check("normal_mem1", {32'd0, tb_mem[1]}, 64'h2C630007);
    $display("load normal: n=2 writes=%0d", we_count - we0);

    // Zero-length image.
    we0 = we_count;
    pulse_start();
    send_len(16'd0, 0);
    check("zero_done_next", {62'd0, done, error}, 64'b10);
    idle_cycles(3);
    check("zero_writes", 64'(we_count - we0), 64'd0);
    $display("load zero: n=0 writes=%0d", we_count - we0);

    // Oversize image, then recovery via a new start.
    we0 = we_count;
    pulse_start();
    send_len(16'd152, 0);
    check("over_err", {61'd0, error, byte_ready, cpu_stall}, 64'b101);
    idle_cycles(4);
    check("over_sticky", {63'd0, error}, 64'd1);
    pulse_start();
    check("over_restart", {62'd0, error, byte_ready}, 64'b01);
    send_len(16'd1, 2);
    send_word(32'hDEADBEEF, 2);
    wait_done(10);
    check("over_writes", 64'(we_count - we0), 64'd1);
    check("over_mem0", {32'd0, tb_mem[0]}, 64'hDEADBEEF);
    $display("load oversize+retry: writes=%0d", we_count - we0);

    // Random images with gaps; a start mid-load must be ignored.
    for (int r = 0; r < 3; r++) begin
      idle_cycles(2);
      we0 = we_count;
      nw  = $urandom_range(1, 12);
      for (int i = 0; i < nw; i++) words[i] = $urandom;
      pulse_start();
      send_len(16'(nw), 10);
      pulse_start();
      for (int i = 0; i < nw; i++) send_word(words[i], 10);
      wait_done(20);
      cyc();
      bad = 0;
      for (int i = 0; i < nw; i++) if (tb_mem[i] !== words[i]) bad++;
      check("rand_image_bad_words", 64'(bad), 64'd0);
      check("rand_writes", 64'(we_count - we0), 64'(nw));
      $display("load random %0d: n=%0d writes=%0d", r, nw, we_count - we0);
    end

    // Timeout after three bytes of word 0.
    idle_cycles(2);
    we0 = we_count;
    pulse_start();
    send_len(16'd1, 0);
    for (int i = 0; i < 3; i++) send_byte(8'(8'hA0 + i), 0);
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      if (error) begin k = i; break; end
    end
    check("timeout_cycle", 64'(k), 64'd16);
    check("timeout_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    check("timeout_writes", 64'(we_count - we0), 64'd0);
    $display("load timeout: err_after=%0d writes=%0d", k, we_count - we0);

    // Reset mid-load after word 0, with a simultaneous start.
    pulse_start();
    we0 = we_count;
    send_len(16'd3, 0);
    send_word(32'h11223344, 0);
    cyc();
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    reset = 1'b1;
    start = 1'b1;
    cyc();
    reset = 1'b0;
    start = 1'b0;
    check("midreset_outputs",
          {31'd0, byte_ready, mem_we, cpu_stall, cpu_reset, busy, done, error, mem_wdata}, 64'd0);
    idle_cycles(5);
    check("midreset_start_ignored", {63'd0, busy}, 64'd0);
    check("midreset_writes", 64'(we_count - we0), 64'd1);
    check("midreset_mem0", {32'd0, tb_mem[0]}, 64'h11223344);
    $display("load midreset: writes=%0d", we_count - we0);

    bad = 0;
    for (int i = 0; i < MEM_WORDS; i++) if (tb_mem[i] !== m_mem[i]) bad++;
    check("mem_image_vs_model", 64'(bad), 64'd0);
    check("addr_in_range", 64'(bad_addr), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
